delay_line_var: RTL

- Parametrised successor to the fixed six-stage sample delay.
- Delays a signed data word by a run-time selectable number of cycles, from 1 to MAX_DELAY.
- Adds per-stage valid tagging, a clock-enable stall, a flush, and a settling indicator that masks output while the delay is being changed.
- Sits in the datapath wherever branches must be time-aligned, e.g. matching filter or multiplier latency.

---
 rtl/delay_pkg.sv | 7 +
 rtl/delay_stage.sv | 27 ++
 rtl/delay_line_var.sv | 74 +++++++
 3 files changed

// File: rtl/delay_pkg.sv
// delay_pkg: shared width default and delay clamping helper for the variable delay line
package delay_pkg;
  localparam int DEFAULT_DATA_W = 25;
  function automatic int clamp_delay(input int sel, input int max);
    return (sel == 0) ? 1 : ((sel > max) ? max : sel);
  endfunction
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one data+valid register of the delay chain with enable, flush and reset
module delay_stage import delay_pkg::*; #(
  parameter int W = DEFAULT_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_valid
);
  logic [W-1:0] r_data;
  logic         r_valid;
  // Flush kills the tag whether or not the stage shifts; data itself is never cleared by flush
  always_ff @(posedge clk)
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (en) r_data <= i_data;
      r_valid <= (en ? i_valid : r_valid) & ~flush;
    end
  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/delay_line_var.sv
// delay_line_var: run-time selectable signed sample delay (1..MAX_DELAY) with valid tags,
// stall, flush and a settling flag that masks the output while the tap moves.
module delay_line_var import delay_pkg::*; #(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 6,
  parameter int SEL_W         = $clog2(MAX_DELAY + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     valid_in,
  input  logic        [SEL_W-1:0]  delay_sel,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     valid_out,
  output logic                     settling
);
  logic [DATA_W-1:0] w_din   [MAX_DELAY];
  logic              w_vin   [MAX_DELAY];
  logic [DATA_W-1:0] w_data  [MAX_DELAY];
  logic              w_valid [MAX_DELAY];
  logic [SEL_W-1:0]  w_eff, w_cnt_nxt, r_cur_delay, r_cnt;
  logic [DATA_W-1:0] w_dsel;
  logic              w_vsel, r_settling;

  for (genvar g = 0; g < MAX_DELAY; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_din[g] = data_in;
      assign w_vin[g] = valid_in;
    end else begin : g_body
      assign w_din[g] = w_data[g-1];
      assign w_vin[g] = w_valid[g-1];
    end
    delay_stage #(.W(DATA_W)) u_stage (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .i_data(w_din[g]), .i_valid(w_vin[g]),
      .o_data(w_data[g]), .o_valid(w_valid[g])
    );
  end

  assign w_eff = SEL_W'(clamp_delay(int'(delay_sel), MAX_DELAY));

  // Change detection runs every cycle so a stalled pipe still notices a new tap
  assign w_cnt_nxt = flush                  ? '0 :
                     (w_eff != r_cur_delay) ? w_eff :
                     (en && r_cnt != '0)    ? r_cnt - SEL_W'(1) : r_cnt;

  always_ff @(posedge clk)
    if (reset) begin
      r_cur_delay <= SEL_W'(DEFAULT_DELAY);
      r_cnt       <= '0;
      r_settling  <= 1'b0;
    end else begin
      r_cur_delay <= w_eff;
      r_cnt       <= w_cnt_nxt;
      r_settling  <= (w_cnt_nxt != '0);
    end

  always_comb begin
    w_dsel = '0;
    w_vsel = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++)
      if (r_cur_delay == SEL_W'(k + 1)) begin
        w_dsel = w_data[k];
        w_vsel = w_valid[k];
      end
  end

  assign data_out  = w_dsel;
  assign valid_out = w_vsel & ~r_settling;
  assign settling  = r_settling;
endmodule
